// File: rtl/bit_serializer.sv
// Parallel-to-serial stage feeding the serial sequence detector: WIDTH-bit words
// in over valid/ready, one bit every DIV clocks on ser_o. Define SERIAL_LSB_FIRST_EN for LSB-first order.
module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             bit_stb_o,
    output logic             busy_o
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [PW-1:0]    pre_cnt_r;
    logic             ser_r;
    logic             stb_r;

    logic             pre_wrap_s;
    logic             last_s;
    logic             ready_s;
    logic             take_s;
    logic             first_bit_s;
    logic             next_bit_s;
    logic [WIDTH-1:0] load_shift_s;
    logic [WIDTH-1:0] adv_shift_s;

    assign pre_wrap_s = (pre_cnt_r == PW'(DIV - 1));
    assign last_s     = (state_r == SHIFT) && (bit_cnt_r == CW'(WIDTH - 1)) && pre_wrap_s;
    assign ready_s    = (state_r == IDLE) || last_s;
    assign take_s     = valid_i && ready_s;

    // The bit currently on ser_o is already removed from shift_r, so shift_r holds only the bits still to come.
`ifdef SERIAL_LSB_FIRST_EN
    assign first_bit_s  = data_i[0];
    assign load_shift_s = {1'b0, data_i[WIDTH-1:1]};
    assign next_bit_s   = shift_r[0];
    assign adv_shift_s  = {1'b0, shift_r[WIDTH-1:1]};
`else
    assign first_bit_s  = data_i[WIDTH-1];
    assign load_shift_s = {data_i[WIDTH-2:0], 1'b0};
    assign next_bit_s   = shift_r[WIDTH-1];
    assign adv_shift_s  = {shift_r[WIDTH-2:0], 1'b0};
`endif

    // Control FSM with registered serial outputs; a transfer at the final edge reloads with no idle gap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            pre_cnt_r <= '0;
            ser_r     <= 1'b0;
            stb_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        state_r   <= SHIFT;
                        shift_r   <= load_shift_s;
                        bit_cnt_r <= '0;
                        pre_cnt_r <= '0;
                        ser_r     <= first_bit_s;
                        stb_r     <= 1'b1;
                    end else begin
                        ser_r <= 1'b0;
                        stb_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (take_s) begin
                        shift_r   <= load_shift_s;
                        bit_cnt_r <= '0;
                        pre_cnt_r <= '0;
                        ser_r     <= first_bit_s;
                        stb_r     <= 1'b1;
                    end else if (last_s) begin
                        state_r   <= IDLE;
                        shift_r   <= '0;
                        bit_cnt_r <= '0;
                        pre_cnt_r <= '0;
                        ser_r     <= 1'b0;
                        stb_r     <= 1'b0;
                    end else if (pre_wrap_s) begin
                        shift_r   <= adv_shift_s;
                        bit_cnt_r <= bit_cnt_r + CW'(1);
                        pre_cnt_r <= '0;
                        ser_r     <= next_bit_s;
                        stb_r     <= 1'b1;
                    end else begin
                        pre_cnt_r <= pre_cnt_r + PW'(1);
                        stb_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    shift_r   <= '0;
                    bit_cnt_r <= '0;
                    pre_cnt_r <= '0;
                    ser_r     <= 1'b0;
                    stb_r     <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = ready_s;
    assign ser_o     = ser_r;
    assign bit_stb_o = stb_r;
    assign busy_o    = (state_r == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: a DIV=1 and a DIV=3 instance, each with
// its own queue of expected per-cycle {ser, stb, ready} values.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d1, d3;
    logic       v1, v3;
    logic       ready1, ser1, stb1, busy1;
    logic       ready3, ser3, stb3, busy3;
    logic       rst_next;

    int checks   = 0;
    int failures = 0;

    logic [2:0] q1[$];
    logic [2:0] q3[$];
    logic [7:0] p1[$];
    logic [7:0] p3[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .data_i(d1), .valid_i(v1),
        .ready_o(ready1), .ser_o(ser1), .bit_stb_o(stb1), .busy_o(busy1)
    );

    bit_serializer #(.WIDTH(8), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .data_i(d3), .valid_i(v3),
        .ready_o(ready3), .ser_o(ser3), .bit_stb_o(stb3), .busy_o(busy3)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int b);
`ifdef SERIAL_LSB_FIRST_EN
        return w[b];
`else
        return w[7-b];
`endif
    endfunction

    // Expected cycles for one accepted word: each bit held div cycles, strobe on the first, ready on the last.
    task automatic push_word(input int sel, input logic [7:0] w);
        int div;
        logic [2:0] e;
        div = (sel == 1) ? 1 : 3;
        for (int b = 0; b < 8; b++) begin
            for (int p = 0; p < div; p++) begin
                e = {exp_bit(w, b), (p == 0), (b == 7 && p == div - 1)};
                if (sel == 1) q1.push_back(e);
                else q3.push_back(e);
            end
        end
    endtask

    task automatic step();
        logic [2:0] e;
        @(negedge clk);
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_eq("d1_ser", ser1, e[2]);
            check_eq("d1_stb", stb1, e[1]);
            check_eq("d1_ready", ready1, e[0]);
            check_eq("d1_busy", busy1, 1);
        end else begin
            check_eq("d1_idle_ser", ser1, 0);
            check_eq("d1_idle_stb", stb1, 0);
            check_eq("d1_idle_ready", ready1, 1);
            check_eq("d1_idle_busy", busy1, 0);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            check_eq("d3_ser", ser3, e[2]);
            check_eq("d3_stb", stb3, e[1]);
            check_eq("d3_ready", ready3, e[0]);
            check_eq("d3_busy", busy3, 1);
        end else begin
            check_eq("d3_idle_ser", ser3, 0);
            check_eq("d3_idle_stb", stb3, 0);
            check_eq("d3_idle_ready", ready3, 1);
            check_eq("d3_idle_busy", busy3, 0);
        end
        rst = rst_next;
        if (!rst) begin
            q1.delete();
            q3.delete();
            v1 = 1'b1;
            d1 = 8'hFF;
            v3 = 1'b1;
            d3 = 8'hFF;
        end else begin
            if (p1.size() > 0) begin
                v1 = 1'b1;
                if (ready1) begin
                    d1 = p1.pop_front();
                    push_word(1, d1);
                end else begin
                    d1 = 8'($urandom);
                end
            end else begin
                v1 = 1'b0;
                d1 = 8'($urandom);
            end
            if (p3.size() > 0) begin
                v3 = 1'b1;
                if (ready3) begin
                    d3 = p3.pop_front();
                    push_word(3, d3);
                end else begin
                    d3 = 8'($urandom);
                end
            end else begin
                v3 = 1'b0;
                d3 = 8'($urandom);
            end
        end
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        while ((q1.size() > 0 || q3.size() > 0 || p1.size() > 0 || p3.size() > 0) && n < 300) begin
            step();
            n++;
        end
        check_eq("drain_in_time", (n < 300), 1);
        step();
        step();
    endtask

    initial begin
        rst      = 1'b0;
        rst_next = 1'b0;
        v1 = 1'b1;
        d1 = 8'hFF;
        v3 = 1'b1;
        d3 = 8'hFF;
        repeat (2) @(negedge clk);
        step();
        rst_next = 1'b1;
        step();

        p1.push_back(8'hB4);
        run_idle();

        p1.push_back(8'hFF);
        p1.push_back(8'h0F);
        run_idle();

        p3.push_back(8'hA5);
        run_idle();

        // Abort after three bits of 8'hFF, then a clean 8'h81.
        p1.push_back(8'hFF);
        step();
        step();
        step();
        rst_next = 1'b0;
        step();
        rst_next = 1'b1;
        step();
        p1.push_back(8'h81);
        run_idle();

        for (int i = 0; i < 4; i++) begin
            p1.push_back(8'($urandom));
            p3.push_back(8'($urandom));
        end
        run_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
